// File: rtl/pifo_sched_pkg.sv
// Shared widths and the push-request record for the PIFO ingress scheduler.
// Lane count and widths are fixed here so every lane FIFO stores the same packed word.
package pifo_sched_pkg;
  localparam int LEVEL = 4;
  localparam int PTW   = 8;
  localparam int TIDW  = 2;

  typedef struct packed {
    logic [TIDW-1:0] tree;
    logic [PTW-1:0]  data;
  } push_req_t;
endpackage

// File: rtl/pifo_req_fifo.sv
// Synchronous FIFO of push requests; data visible at head with zero read latency.
// Full/empty are registered from next-state pointers; writes when full and reads when empty are ignored.
module pifo_req_fifo
  import pifo_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr,
  input  push_req_t              i_wr_dat,
  input  logic                   i_rd,
  output push_req_t              o_rd_dat,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  push_req_t   r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_full;
  logic        r_empty;
  logic        w_wr;
  logic        w_rd;
  logic [AW:0] w_wptr_nxt;
  logic [AW:0] w_rptr_nxt;

  assign w_wr       = i_wr & ~r_full;
  assign w_rd       = i_rd & ~r_empty;
  assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_wr};
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_rd};

  // Extra pointer MSB distinguishes a full ring from an empty one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
      r_full  <= (w_wptr_nxt == {~w_rptr_nxt[AW], w_rptr_nxt[AW-1:0]});
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[r_rptr[AW-1:0]];
  assign o_full   = r_full;
  assign o_count  = r_wptr - r_rptr;
endmodule

// File: rtl/pifo_ingress_sched.sv
// Per-lane issue stage in front of the PIFO: pop beats push, occupancy bounded to 0..CAP.
// PIFO-side outputs are registered (1 cycle); pop results return 1+POP_LAT+1 cycles after pop accept.
module pifo_ingress_sched
  import pifo_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CAP        = 16,
  parameter int POP_LAT    = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [LEVEL-1:0]                  i_push_valid,
  output logic [LEVEL-1:0]                  o_push_ready,
  input  logic [LEVEL*PTW-1:0]              i_push_data,
  input  logic [LEVEL*TIDW-1:0]             i_push_tree,
  input  logic [LEVEL-1:0]                  i_pop_valid,
  output logic [LEVEL-1:0]                  o_pop_ready,
  input  logic [LEVEL*TIDW-1:0]             i_pop_tree,
  output logic [LEVEL-1:0]                  o_push,
  output logic [LEVEL*PTW-1:0]              o_push_data,
  output logic [LEVEL-1:0]                  o_pop,
  output logic [LEVEL*TIDW-1:0]             o_tree_id,
  input  logic [LEVEL*PTW-1:0]              i_pif_pop_data,
  output logic [LEVEL-1:0]                  o_pop_valid,
  output logic [LEVEL*PTW-1:0]              o_pop_data,
  output logic [LEVEL*$clog2(CAP+1)-1:0]    o_occ
);
  localparam int OW = $clog2(CAP+1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  for (genvar j = 0; j < LEVEL; j++) begin : g_lane
    push_req_t          w_wr_dat;
    push_req_t          w_head;
    logic               w_full;
    logic               w_push_rdy;
    logic               w_pop_acc;
    logic               w_deq;
    logic [CW-1:0]      w_cnt;
    logic [OW-1:0]      r_occ;
    logic [POP_LAT-1:0] r_pipe;
    logic               r_push;
    logic               r_pop;
    logic               r_pop_vld;
    logic [TIDW-1:0]    r_tree;
    logic [PTW-1:0]     r_push_data;
    logic [PTW-1:0]     r_pop_data;

    assign w_wr_dat   = {i_push_tree[j*TIDW +: TIDW], i_push_data[j*PTW +: PTW]};
    assign w_push_rdy = ~w_full & ~i_rst;
    assign w_pop_acc  = i_pop_valid[j] & (r_occ != '0) & ~i_rst;
    assign w_deq      = (w_cnt != '0) & (r_occ < OW'(CAP)) & ~w_pop_acc;

    pifo_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_wr     (i_push_valid[j] & w_push_rdy),
      .i_wr_dat (w_wr_dat),
      .i_rd     (w_deq),
      .o_rd_dat (w_head),
      .o_full   (w_full),
      .o_count  (w_cnt)
    );

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_push      <= 1'b0;
        r_pop       <= 1'b0;
        r_tree      <= '0;
        r_push_data <= '0;
        r_occ       <= '0;
        r_pipe      <= '0;
        r_pop_vld   <= 1'b0;
        r_pop_data  <= '0;
      end else begin
        r_push <= w_deq;
        r_pop  <= w_pop_acc;
        if (w_pop_acc) begin
          r_tree <= i_pop_tree[j*TIDW +: TIDW];
        end else if (w_deq) begin
          r_tree <= w_head.tree;
        end
        if (w_deq) begin
          r_push_data <= w_head.data;
          r_occ       <= r_occ + OW'(1);
        end else if (w_pop_acc) begin
          r_occ <= r_occ - OW'(1);
        end
        // Each issued pop travels the pipe; its tap marks PIFO data valid at the input.
        r_pipe    <= (r_pipe << 1) | POP_LAT'(r_pop);
        r_pop_vld <= r_pipe[POP_LAT-1];
        if (r_pipe[POP_LAT-1]) begin
          r_pop_data <= i_pif_pop_data[j*PTW +: PTW];
        end
      end
    end

    assign o_push_ready[j]            = w_push_rdy;
    assign o_pop_ready[j]             = w_pop_acc;
    assign o_push[j]                  = r_push;
    assign o_pop[j]                   = r_pop;
    assign o_push_data[j*PTW +: PTW]  = r_push_data;
    assign o_tree_id[j*TIDW +: TIDW]  = r_tree;
    assign o_pop_valid[j]             = r_pop_vld;
    assign o_pop_data[j*PTW +: PTW]   = r_pop_data;
    assign o_occ[j*OW +: OW]          = r_occ;
  end
endmodule
